// File: rtl/conv1d_cmd_sequencer_if.sv
// CFU command/response bus between the CPU (master) and the conv1d sequencer (slave).
interface conv1d_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0
    );
    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0
    );
endinterface

// File: rtl/conv1d_cmd_sequencer.sv
// Issues one CFU command at a time to the conv1d datapath and returns its result,
// with a bounded wait for long ops and a local status command for timeout diagnostics.
module conv1d_cmd_sequencer #(
    parameter logic [6:0]  LONG_OP_BASE   = 7'd16,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [6:0]  STATUS_FUNCT7  = 7'h7F,
    parameter logic [31:0] TIMEOUT_CODE   = 32'hDEAD_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    conv1d_cmd_sequencer_if.slave        cfu,
    output logic [6:0]                   dp_cmd,
    output logic [31:0]                  dp_inp0,
    output logic [31:0]                  dp_inp1,
    output logic                         dp_strobe,
    input  logic [31:0]                  dp_ret,
    input  logic                         dp_done
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        r_state, w_nxt;
    logic [6:0]    r_dp_cmd;
    logic [31:0]   r_dp_inp0, r_dp_inp1, r_rsp_data;
    logic          r_strobe, r_rsp_valid, r_err;
    logic [15:0]   r_tocnt;
    logic [6:0]    r_last_to;
    logic [CW-1:0] r_wcnt;

    logic [6:0]    w_f7;
    logic          w_accept, w_is_status, w_long, w_expire, w_unused_fid;

    assign w_f7         = cfu.cmd_payload_function_id[9:3];
    assign w_unused_fid = ^cfu.cmd_payload_function_id[2:0];
    assign w_accept     = cfu.cmd_valid && (r_state == IDLE);
    assign w_is_status  = (w_f7 == STATUS_FUNCT7);
    assign w_long       = (r_dp_cmd >= LONG_OP_BASE);
    // Expiry only counts when dp_done is absent, so a same-cycle done wins.
    assign w_expire     = w_long && !dp_done && (r_wcnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_nxt = w_is_status ? RESP : ISSUE;
            ISSUE: w_nxt = WAIT;
            WAIT:  if (!w_long || dp_done || w_expire) w_nxt = RESP;
            RESP:  if (cfu.rsp_ready) w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dp_cmd    <= '0;
            r_dp_inp0   <= '0;
            r_dp_inp1   <= '0;
            r_rsp_data  <= '0;
            r_strobe    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_tocnt     <= '0;
            r_last_to   <= '0;
            r_wcnt      <= '0;
        end else begin
            r_strobe    <= (w_nxt == ISSUE);
            r_rsp_valid <= (w_nxt == RESP);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_status) begin
                            // Status read reports err as it was, then clears it.
                            r_rsp_data <= {r_err, r_last_to, 8'h00, r_tocnt};
                            r_err      <= 1'b0;
                        end else begin
                            r_dp_cmd  <= w_f7;
                            r_dp_inp0 <= cfu.cmd_payload_inputs_0;
                            r_dp_inp1 <= cfu.cmd_payload_inputs_1;
                        end
                    end
                end
                ISSUE: r_wcnt <= '0;
                WAIT: begin
                    if (!w_long || dp_done) begin
                        r_rsp_data <= dp_ret;
                    end else if (w_expire) begin
                        r_rsp_data <= TIMEOUT_CODE;
                        r_err      <= 1'b1;
                        r_last_to  <= r_dp_cmd;
                        if (r_tocnt != 16'hFFFF) r_tocnt <= r_tocnt + 16'd1;
                    end else begin
                        r_wcnt <= r_wcnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cfu.cmd_ready             = (r_state == IDLE);
    assign cfu.rsp_valid             = r_rsp_valid;
    assign cfu.rsp_payload_outputs_0 = r_rsp_data;
    assign dp_cmd    = r_dp_cmd;
    assign dp_inp0   = r_dp_inp0;
    assign dp_inp1   = r_dp_inp1;
    assign dp_strobe = r_strobe;
endmodule

// File: tb/tb_conv1d_cmd_sequencer.sv
// Directed bench for conv1d_cmd_sequencer with a short timeout so expiry is reachable.
module tb_conv1d_cmd_sequencer;
    logic        clk, reset;
    logic [6:0]  dp_cmd;
    logic [31:0] dp_inp0, dp_inp1, dp_ret;
    logic        dp_strobe, dp_done;
    int          n_cmp, n_err;

    conv1d_cmd_sequencer_if cfu();

    conv1d_cmd_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .cfu(cfu),
        .dp_cmd(dp_cmd), .dp_inp0(dp_inp0), .dp_inp1(dp_inp1),
        .dp_strobe(dp_strobe), .dp_ret(dp_ret), .dp_done(dp_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] f7, input logic [2:0] lo, input logic [31:0] a, input logic [31:0] b);
        cfu.cmd_valid = 1'b1;
        cfu.cmd_payload_function_id = {f7, lo};
        cfu.cmd_payload_inputs_0 = a;
        cfu.cmd_payload_inputs_1 = b;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b1; dp_ret = '0; dp_done = 1'b0;
        cfu.cmd_valid = 1'b0; cfu.cmd_payload_function_id = '0;
        cfu.cmd_payload_inputs_0 = '0; cfu.cmd_payload_inputs_1 = '0; cfu.rsp_ready = 1'b1;
        tick(); tick();
        chk("rst_rsp_valid", 32'(cfu.rsp_valid), 0);
        chk("rst_strobe", 32'(dp_strobe), 0);
        chk("rst_dp_cmd", 32'(dp_cmd), 0);
        chk("rst_dp_inp0", dp_inp0, 0);
        chk("rst_payload", cfu.rsp_payload_outputs_0, 0);
        reset = 1'b0;
        tick();
        chk("rst_cmd_ready", 32'(cfu.cmd_ready), 1);

        // Short op: c0 accept
        dp_ret = 32'h1234_5678;
        send(7'd3, 3'b000, 32'h11, 32'h22);
        tick();                                   // c1
        cfu.cmd_valid = 1'b0;
        chk("short_strobe_c1", 32'(dp_strobe), 1);
        chk("short_dp_cmd", 32'(dp_cmd), 3);
        chk("short_dp_inp0", dp_inp0, 32'h11);
        chk("short_dp_inp1", dp_inp1, 32'h22);
        chk("short_ready_c1", 32'(cfu.cmd_ready), 0);
        tick();                                   // c2
        chk("short_strobe_c2", 32'(dp_strobe), 0);
        chk("short_rsp_c2", 32'(cfu.rsp_valid), 0);
        chk("short_ready_c2", 32'(cfu.cmd_ready), 0);
        tick();                                   // c3
        chk("short_rsp_c3", 32'(cfu.rsp_valid), 1);
        chk("short_data", cfu.rsp_payload_outputs_0, 32'h1234_5678);
        chk("short_ready_c3", 32'(cfu.cmd_ready), 0);
        tick();                                   // handshake done
        chk("short_rsp_drop", 32'(cfu.rsp_valid), 0);
        chk("short_idle_ready", 32'(cfu.cmd_ready), 1);

        // Stray dp_done in IDLE must be ignored
        dp_done = 1'b1; dp_ret = 32'h0BAD_0BAD;
        tick();
        dp_done = 1'b0;
        chk("idle_done_rsp", 32'(cfu.rsp_valid), 0);
        chk("idle_done_ready", 32'(cfu.cmd_ready), 1);

        // Long op, done at c7
        send(7'd20, 3'b101, 32'hA, 32'hB);
        tick();                                   // c1
        cfu.cmd_valid = 1'b0;
        chk("long_dp_cmd", 32'(dp_cmd), 20);
        for (int i = 2; i <= 7; i++) tick();      // c7
        chk("long_rsp_c7", 32'(cfu.rsp_valid), 0);
        dp_done = 1'b1; dp_ret = 32'hCAFE_0001;
        tick();                                   // c8
        dp_done = 1'b0;
        chk("long_rsp_c8", 32'(cfu.rsp_valid), 1);
        chk("long_data", cfu.rsp_payload_outputs_0, 32'hCAFE_0001);
        tick();

        // Timeout: rsp from c10
        send(7'd21, 3'b000, 32'h0, 32'h0);
        tick();
        cfu.cmd_valid = 1'b0;
        for (int i = 2; i <= 9; i++) tick();      // c9
        chk("to_rsp_c9", 32'(cfu.rsp_valid), 0);
        tick();                                   // c10
        chk("to_rsp_c10", 32'(cfu.rsp_valid), 1);
        chk("to_data", cfu.rsp_payload_outputs_0, 32'hDEAD_0000);
        tick();

        send(7'h7F, 3'b000, 32'h0, 32'h0);
        tick();                                   // c1
        cfu.cmd_valid = 1'b0;
        chk("stat1_rsp_c1", 32'(cfu.rsp_valid), 1);
        chk("stat1_data", cfu.rsp_payload_outputs_0, 32'h9500_0001);
        chk("stat1_no_strobe", 32'(dp_strobe), 0);
        chk("stat1_dp_cmd_kept", 32'(dp_cmd), 21);
        tick();
        send(7'h7F, 3'b011, 32'h0, 32'h0);
        tick();
        cfu.cmd_valid = 1'b0;
        chk("stat2_data", cfu.rsp_payload_outputs_0, 32'h1500_0001);
        tick();

        // Done on the 8th WAIT cycle (c9) beats the timeout
        send(7'd22, 3'b000, 32'h0, 32'h0);
        tick();
        cfu.cmd_valid = 1'b0;
        for (int i = 2; i <= 9; i++) tick();      // c9
        dp_done = 1'b1; dp_ret = 32'h55;
        tick();                                   // c10
        dp_done = 1'b0;
        chk("tie_rsp", 32'(cfu.rsp_valid), 1);
        chk("tie_data", cfu.rsp_payload_outputs_0, 32'h55);
        tick();
        send(7'h7F, 3'b000, 32'h0, 32'h0);
        tick();
        cfu.cmd_valid = 1'b0;
        chk("tie_status", cfu.rsp_payload_outputs_0, 32'h1500_0001);
        tick();

        // Backpressure: rsp_ready low c3..c7, handshake c8, accept c9
        cfu.rsp_ready = 1'b0; dp_ret = 32'hA5A5_A5A5;
        send(7'd5, 3'b000, 32'h1, 32'h2);
        tick(); tick(); tick();                   // c3
        send(7'd6, 3'b000, 32'h3, 32'h4);
        for (int i = 0; i < 5; i++) begin
            dp_ret = 32'h0;
            chk("bp_rsp_held", 32'(cfu.rsp_valid), 1);
            chk("bp_data_stable", cfu.rsp_payload_outputs_0, 32'hA5A5_A5A5);
            chk("bp_not_ready", 32'(cfu.cmd_ready), 0);
            tick();
        end
        cfu.rsp_ready = 1'b1;                     // c8
        chk("bp_rsp_c8", 32'(cfu.rsp_valid), 1);
        tick();                                   // c9
        chk("bp_rsp_c9", 32'(cfu.rsp_valid), 0);
        chk("bp_ready_c9", 32'(cfu.cmd_ready), 1);
        chk("bp_strobe_c9", 32'(dp_strobe), 0);
        tick();                                   // c10
        cfu.cmd_valid = 1'b0;
        chk("bp_strobe_c10", 32'(dp_strobe), 1);
        chk("bp_dp_cmd", 32'(dp_cmd), 6);
        tick(); tick(); tick();

        // Reset mid-WAIT
        send(7'd23, 3'b000, 32'h0, 32'h0);
        tick();
        cfu.cmd_valid = 1'b0;
        tick(); tick(); tick();                   // c4
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_rsp", 32'(cfu.rsp_valid), 0);
        chk("mrst_ready", 32'(cfu.cmd_ready), 1);
        chk("mrst_dp_cmd", 32'(dp_cmd), 0);
        dp_done = 1'b1; dp_ret = 32'h7777;
        tick();
        dp_done = 1'b0;
        chk("mrst_late_done", 32'(cfu.rsp_valid), 0);
        send(7'h7F, 3'b000, 32'h0, 32'h0);
        tick();
        cfu.cmd_valid = 1'b0;
        chk("mrst_status_vld", 32'(cfu.rsp_valid), 1);
        chk("mrst_status", cfu.rsp_payload_outputs_0, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/conv1d_cmd_sequencer.md
Name: conv1d_cmd_sequencer

Overview:
- Sits between the CPU's CFU command/response bus and the conv1d datapath.
- Accepts one CFU command at a time, issues it to the datapath as a one-cycle strobe with stable operands, then captures the result:
  - short ops: fixed latency;
  - long ops: waits for the datapath done flag, bounded by a timeout.
- Returns the result over the rsp handshake.
- Adds a local status/diagnostic command and sticky timeout error reporting so firmware can detect a hung datapath.

Parameters:
- LONG_OP_BASE, 7'd16, funct7 values >= this (and != STATUS_FUNCT7) are long ops that wait for dp_done.
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles for a long op before it is aborted (must be >= 2).
- STATUS_FUNCT7, 7'h7F, funct7 serviced locally and never sent to the datapath.
- TIMEOUT_CODE, 32'hDEAD_0000, response word returned for a timed-out op.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  CPU command valid
- cmd_ready  out  1  sequencer can accept a command
- cmd_payload_function_id  in  10  funct7 = bits [9:3]; bits [2:0] ignored
- cmd_payload_inputs_0  in  32  operand 0
- cmd_payload_inputs_1  in  32  operand 1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  CPU accepts response
- rsp_payload_outputs_0  out  32  response data
- dp_cmd  out  7  funct7 to datapath
- dp_inp0  out  32  operand 0 to datapath
- dp_inp1  out  32  operand 1 to datapath
- dp_strobe  out  1  one-cycle issue pulse
- dp_ret  in  32  datapath result
- dp_done  in  1  datapath long-op result valid (same role as output_buffer_valid)

Behaviour:
- Reset values:
  - rsp_valid=0, dp_strobe=0; dp_cmd/dp_inp0/dp_inp1/rsp_payload_outputs_0 = 0.
  - State IDLE; err flag, timeout counter, last_to_funct7 and wait counter all 0.
  - cmd_ready=1 in the first cycle after reset deasserts.
- States: IDLE, ISSUE, WAIT, RESP. All outputs registered except cmd_ready, which is 1 iff state==IDLE.
- IDLE:
  - Accept when cmd_valid && cmd_ready; latch funct7 and operands into dp_cmd/dp_inp0/dp_inp1.
  - funct7==STATUS_FUNCT7: load the status word, clear err, go to RESP. No strobe; dp_* registers keep their previous values.
  - Otherwise go to ISSUE.
- ISSUE: dp_strobe=1 for exactly this cycle; wait counter cleared; go to WAIT.
- WAIT, short op (funct7 < LONG_OP_BASE): capture dp_ret at the end of the first WAIT cycle; go to RESP.
- WAIT, long op:
  - dp_done=1 in a WAIT cycle: capture dp_ret; go to RESP.
  - After TIMEOUT_CYCLES WAIT cycles with no dp_done:
    - response = TIMEOUT_CODE;
    - err=1;
    - timeout counter +1, saturating at 16'hFFFF;
    - last_to_funct7 = dp_cmd;
    - go to RESP.
  - dp_done in the same cycle as the timeout expiry wins: normal capture, no error.
- RESP: rsp_valid=1 with stable payload until rsp_valid && rsp_ready, then go to IDLE (rsp_valid=0 next cycle).
- Latency, with c0 = the accept cycle:
  - short op: ISSUE c1, WAIT c2, rsp_valid from c3;
  - long op with dp_done at c2+k: rsp_valid from c3+k;
  - timeout: rsp_valid from c2+TIMEOUT_CYCLES;
  - status op: rsp_valid from c1.
- Minimum gap between back-to-back accepts: response handshake cycle + 1.
- dp_cmd/dp_inp0/dp_inp1 hold from ISSUE through RESP. dp_done and dp_ret are ignored outside WAIT.
- Status word: bit31 = err; bits[30:24] = last_to_funct7; bits[23:16] = 0; bits[15:0] = timeout count.
  - The status read clears err only; count and last_to_funct7 persist until reset.
- Reset in any state, including mid-WAIT or RESP: immediate return to IDLE with all reset values. The pending op is dropped with no response. The datapath is not notified beyond dp_strobe=0.
- cmd_payload_function_id[2:0] does not affect behaviour.

Test Plan:
- Short op: reset, send funct7=3, inputs 0x11/0x22, dp_ret=0x1234_5678, rsp_ready=1 -> dp_strobe exactly 1 cycle at c1 with dp_cmd=3, dp_inp0=0x11, dp_inp1=0x22; rsp_valid at c3 with 0x1234_5678; cmd_ready=0 during c1..c3.
- Long op: funct7=20, dp_done pulsed at c7 with dp_ret=0xCAFE_0001 -> rsp_valid from c8 with 0xCAFE_0001; a dp_done pulse injected in IDLE beforehand has no effect.
- Timeout (TIMEOUT_CYCLES=8): funct7=21, dp_done held 0 -> rsp_valid at c10 with 0xDEAD_0000; a following status read returns 0x9500_0001 (bit31=1, bits[30:24]=21=0x15, count=1); a second status read returns 0x1500_0001.
- Done/timeout tie (TIMEOUT_CYCLES=8): dp_done at the 8th WAIT cycle with dp_ret=0x55 -> response 0x55; err stays 0; count unchanged.
- Response backpressure: rsp_ready held 0 for 5 cycles after rsp_valid -> payload stable, rsp_valid held, cmd_valid ignored; accept occurs only the cycle after the handshake.
- Reset mid-WAIT: long op, reset asserted at c4 -> next cycle rsp_valid=0, cmd_ready=1, status read returns 0; a late dp_done after reset is ignored.
